// File: rtl/para_rom_ctrl_if.sv
// rtl/para_rom_ctrl_if.sv - parameter ROM beat stream between sequencer and conv engine
interface para_rom_ctrl_if;
   logic [7:0] param_rd_addr;
   logic [4:0] conv_cnt;
   logic       param_vld;
   logic       param_first;
   logic       param_last;
   logic       param_rdy;

   modport master (
      output param_rd_addr, conv_cnt, param_vld, param_first, param_last,
      input  param_rdy
   );
   modport slave (
      input  param_rd_addr, conv_cnt, param_vld, param_first, param_last,
      output param_rdy
   );
endinterface

// File: rtl/para_rom_ctrl.sv
// rtl/para_rom_ctrl.sv - parameter ROM sequencer; PARA_ROM_CTRL_RANGE_EN adds k_first/k_last kernel range with SEEK
module para_rom_ctrl #(
   parameter int OUT_CH = 6,
   parameter int WORDS  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
`ifdef PARA_ROM_CTRL_RANGE_EN
   input  logic [4:0]            k_first,
   input  logic [4:0]            k_last,
`endif
   para_rom_ctrl_if.master       bus,
   output logic                  busy,
   output logic                  done
);
   localparam logic [4:0] W_MAX = 5'(WORDS - 1);
   localparam logic [4:0] K_MAX = 5'(OUT_CH - 1);
`ifdef PARA_ROM_CTRL_RANGE_EN
   localparam logic [7:0] W8    = 8'(WORDS);
`endif

   typedef enum logic [1:0] {
      IDLE,
`ifdef PARA_ROM_CTRL_RANGE_EN
      SEEK,
`endif
      STREAM,
      DONE
   } state_t;

   state_t     state;
   logic [4:0] cur_k;
   logic [4:0] cur_w;
   logic [7:0] cur_addr;
   logic       vld;
   logic [4:0] k_end;
   logic [4:0] nxt_k;
   logic [4:0] nxt_w;
   logic       fire;
   logic       final_beat;

`ifdef PARA_ROM_CTRL_RANGE_EN
   logic [4:0] k_first_r;
   logic [4:0] k_last_r;
   assign k_end = k_last_r;
`else
   assign k_end = K_MAX;
`endif

   assign fire       = vld & bus.param_rdy;
   assign final_beat = (cur_w == W_MAX) && (cur_k == k_end);
   assign nxt_w      = (cur_w == W_MAX) ? 5'd0 : cur_w + 5'd1;
   assign nxt_k      = (cur_w == W_MAX) ? cur_k + 5'd1 : cur_k;

   // Look one entry ahead on an accepted beat so the 1-cycle ROMs track param_vld.
   assign bus.param_rd_addr = fire ? (final_beat ? 8'd0 : cur_addr + 8'd1) : cur_addr;
   assign bus.conv_cnt      = fire ? (final_beat ? 5'd0 : nxt_k) : cur_k;
   assign bus.param_vld     = vld;
   assign bus.param_first   = vld & (cur_w == 5'd0);
   assign bus.param_last    = vld & (cur_w == W_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_k    <= 5'd0;
         cur_w    <= 5'd0;
         cur_addr <= 8'd0;
         vld      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef PARA_ROM_CTRL_RANGE_EN
         k_first_r <= 5'd0;
         k_last_r  <= 5'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
`ifdef PARA_ROM_CTRL_RANGE_EN
                  k_first_r <= k_first;
                  k_last_r  <= k_last;
                  if ((k_first > k_last) || (k_last > K_MAX)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SEEK;
                     busy  <= 1'b1;
                  end
`else
                  state <= STREAM;
                  vld   <= 1'b1;
                  busy  <= 1'b1;
`endif
               end
            end
`ifdef PARA_ROM_CTRL_RANGE_EN
            SEEK: begin
               // cur_addr reaches k_first*WORDS by one addition per kernel skipped.
               if (cur_k == k_first_r) begin
                  state <= STREAM;
                  vld   <= 1'b1;
               end else begin
                  cur_k    <= cur_k + 5'd1;
                  cur_addr <= cur_addr + W8;
               end
            end
`endif
            STREAM: begin
               if (bus.param_rdy) begin
                  if (final_beat) begin
                     state    <= DONE;
                     vld      <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cur_k    <= 5'd0;
                     cur_w    <= 5'd0;
                     cur_addr <= 8'd0;
                  end else begin
                     cur_w    <= nxt_w;
                     cur_k    <= nxt_k;
                     cur_addr <= cur_addr + 8'd1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               cur_k    <= 5'd0;
               cur_w    <= 5'd0;
               cur_addr <= 8'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/para_rom_ctrl.md
# para_rom_ctrl

Sequencer for the convolution parameter ROM bank: walks the five weight-row ROMs (shared address) and the bias ROM (indexed by kernel number) through every output-channel kernel in order. It presents one kernel word (five row weights) plus that kernel's bias to the convolution engine per accepted beat, under a valid/ready handshake. It sits between the layer controller (start/done) and the parameter ROM bank, driving the bank's `param_rd_addr` and `conv_cnt` inputs.

## Interface
- `OUT_CH`, 6: kernels (output channels) per layer; 1..32.
- `WORDS`, 5: ROM words (kernel columns) per kernel; 1..32; `OUT_CH*WORDS` ≤ 256.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle request to stream a full parameter pass; honoured only in IDLE.
- `param_rdy`  in  1  conv engine accepts the current beat.
- `param_rd_addr`  out  8  weight ROM address presented this cycle.
- `conv_cnt`  out  5  kernel index presented this cycle; drives bias ROM address.
- `param_vld`  out  1  ROM outputs this cycle hold the word for the current entry.
- `param_first`  out  1  current beat is word 0 of a kernel (bias is fresh).
- `param_last`  out  1  current beat is word `WORDS-1` of a kernel.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, STREAM, DONE.
- Registered cursor `cur_k` (0..OUT_CH-1), `cur_w` (0..WORDS-1), `cur_addr` (8 bit). `cur_addr` is maintained incrementally (+1 per beat); no multiplier.
- Presented address: `fire = param_vld & param_rdy`. When `fire`, `param_rd_addr`/`conv_cnt` present the next entry; otherwise they present the cursor. The 1-cycle-latency ROMs therefore always output the data of the entry `param_vld` refers to, including across stalls.
- IDLE: cursor = 0, presented address 0 / conv_cnt 0, `param_vld`=0. On `start` -> STREAM.
- STREAM: `param_vld`=1. On `fire`: `cur_w`+1, `cur_addr`+1. On `cur_w` wrapping from `WORDS-1` to 0, `cur_k`+1. On `fire` with `cur_k=OUT_CH-1` and `cur_w=WORDS-1` -> DONE.
- DONE: `done`=1 for one cycle, `param_vld`=0, cursor cleared -> IDLE.
- `param_first` = (`cur_w`==0) & `param_vld`; `param_last` = (`cur_w`==WORDS-1) & `param_vld`.
- `start` in STREAM or DONE is ignored (no queueing).
- `param_rdy` while `param_vld`=0 has no effect.

## Timing
- Reset (synchronous, `rst_n`=0 at an edge): state IDLE; all outputs 0 (`param_rd_addr`=0, `conv_cnt`=0, `param_vld`=0, `param_first`=0, `param_last`=0, `busy`=0, `done`=0); cursor cleared. Reset mid-stream abandons the pass with no `done`.
- `start` at cycle t -> `param_vld`=1 with word 0 data at t+1 (ROM latency 1).
- With `param_rdy` held high: one beat per cycle; `OUT_CH*WORDS` beats at t+1..t+N; `done` at t+N+1; `start` accepted again at t+N+2.
- Stall: while `param_vld`=1 and `param_rdy`=0, presented address, ROM data, `param_vld`, `param_first`, and `param_last` are stable.
- `conv_cnt` steps in the same cycle that the address of word 0 of the next kernel is presented. Bias data is therefore aligned with that kernel's `param_first` beat.

## Configuration
- `PARA_ROM_CTRL_RANGE_EN` defined: adds inputs `k_first`[4:0] and `k_last`[4:0], sampled on accepted `start`. Streaming covers kernels `k_first..k_last` only; the cursor starts at `k_first`, with `cur_addr` = `k_first*WORDS`, computed by repeated addition during a one-cycle-per-kernel SEEK state before STREAM.
  - If `k_first>k_last` or `k_last≥OUT_CH`: go straight to DONE with no beats.
- Undefined: no extra ports; always 0..OUT_CH-1, no SEEK state.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles, including with `param_rdy`=1 and with `rst_n` pulsed mid-stream.
- Defaults, `param_rdy`=1, `start` at cycle 5: addresses 0..29 are presented on cycles 5..34 with `param_vld` on 6..35. `conv_cnt` steps at addresses 5, 10, 15, 20, 25. `param_first` occurs on beats 0, 5, …, 25; `param_last` on beats 4, 9, …, 29. `done` at cycle 36.
- Random `param_rdy` (50%): every beat index 0..29 is delivered exactly once, in order, with data matching the ROM image. Data is stable across every stall.
- `start` pulsed while busy (beat 12): ignored; a single `done`, beat count stays 30.
- Back-to-back: `start` on the cycle after `done`: a second full pass of 30 beats with identical data.
- `PARA_ROM_CTRL_RANGE_EN`, `k_first`=2, `k_last`=3: beats at addresses 10..19 only, with `conv_cnt` 2 then 3. With `k_first`=4, `k_last`=1: `done` with zero beats.
